// File: rtl/tsmac_apb_cfg_slave.sv
// APB slave register bank holding the tri-speed MAC static configuration
// (MAC1/MAC2, address filter, station address) plus status and commit signalling.
module tsmac_apb_cfg_slave #(
    parameter int unsigned   WAIT_STATES = 0,
    parameter logic [7:0]    MAC1_RST    = 8'h00,
    parameter logic [15:0]   MAC2_RST    = 16'h0000,
    parameter logic [15:0]   FIR_RST     = 16'h0000
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        pselx,
    input  logic        pwrite,
    input  logic        penable,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [7:0]  mac1_cfg,
    output logic [15:0] mac2_cfg,
    output logic [15:0] fir_cfg,
    output logic [47:0] mac_addr,
    output logic        cfg_update,
    output logic        cfg_valid,
    output logic        proto_err
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    localparam logic [1:0] WaitMax = 2'(WAIT_STATES);

    state_e      state;
    logic [1:0]  wait_cnt;
    logic [7:0]  addr_q;
    logic        write_q;
    logic [31:0] mac_l;
    logic [4:0]  seen;
    logic [31:0] rd_data;
    logic        hit;

    always_comb begin
        hit     = 1'b1;
        rd_data = 32'h0;
        case (addr_q)
            8'h00:   rd_data = {24'h0, mac1_cfg};
            8'h01:   rd_data = {16'h0, mac2_cfg};
            8'h12:   rd_data = {16'h0, fir_cfg};
            8'h13:   rd_data = mac_l;
            8'h14:   rd_data = {mac_addr[47:32], 16'h0};
            8'h20:   rd_data = {30'h0, proto_err, cfg_valid};
            default: hit = 1'b0;
        endcase
    end

    assign pready  = (state == StAccess) && (wait_cnt == WaitMax);
    assign prdata  = pready ? rd_data : 32'h0;
    assign pslverr = pready & ~hit;

    always_ff @(posedge pclk) begin
        if (presetn) begin
            state      <= StIdle;
            wait_cnt   <= 2'd0;
            addr_q     <= 8'h0;
            write_q    <= 1'b0;
            mac1_cfg   <= MAC1_RST;
            mac2_cfg   <= MAC2_RST;
            fir_cfg    <= FIR_RST;
            mac_addr   <= 48'h0;
            mac_l      <= 32'h0;
            seen       <= 5'h0;
            cfg_update <= 1'b0;
            cfg_valid  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            cfg_valid  <= cfg_valid | (seen == 5'h1F);
            case (state)
                StIdle: begin
                    if (pselx && !penable) begin
                        state   <= StSetup;
                        addr_q  <= paddr;
                        write_q <= pwrite;
                    end else if (pselx && penable) begin
                        proto_err <= 1'b1;
                    end
                end
                StSetup: begin
                    if (pselx && penable) begin
                        state    <= StAccess;
                        wait_cnt <= 2'd0;
                    end else begin
                        state <= StIdle;
                        if (!pselx) proto_err <= 1'b1;
                    end
                end
                StAccess: begin
                    if (pready) begin
                        if (write_q) begin
                            case (addr_q)
                                8'h00: begin
                                    mac1_cfg   <= pwdata[7:0];
                                    seen[0]    <= 1'b1;
                                    cfg_update <= 1'b1;
                                end
                                8'h01: begin
                                    mac2_cfg   <= pwdata[15:0];
                                    seen[1]    <= 1'b1;
                                    cfg_update <= 1'b1;
                                end
                                8'h12: begin
                                    fir_cfg    <= pwdata[15:0];
                                    seen[2]    <= 1'b1;
                                    cfg_update <= 1'b1;
                                end
                                8'h13: begin
                                    mac_l      <= pwdata;
                                    seen[3]    <= 1'b1;
                                    cfg_update <= 1'b1;
                                end
                                // High half commits the whole station address at once
                                8'h14: begin
                                    mac_addr   <= {pwdata[31:16], mac_l};
                                    seen[4]    <= 1'b1;
                                    cfg_update <= 1'b1;
                                end
                                8'h20: if (pwdata[1]) proto_err <= 1'b0;
                                default: ;
                            endcase
                        end
                        if (pselx && !penable) begin
                            state   <= StSetup;
                            addr_q  <= paddr;
                            write_q <= pwrite;
                        end else begin
                            state <= StIdle;
                        end
                    end else if (!(pselx && penable)) begin
                        proto_err <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tsmac_apb_cfg_slave.sv
// Directed bench for tsmac_apb_cfg_slave: a zero-wait instance with non-zero reset
// values for the register-map scenarios and a two-wait instance for pready timing.
module tb_tsmac_apb_cfg_slave;

    logic        pclk = 1'b0;
    logic        presetn = 1'b1;
    logic        pselx = 1'b0, pwrite = 1'b0, penable = 1'b0;
    logic [7:0]  paddr = 8'h0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready, pslverr, cfg_update, cfg_valid, proto_err;
    logic [7:0]  mac1_cfg;
    logic [15:0] mac2_cfg, fir_cfg;
    logic [47:0] mac_addr;

    logic        psel1 = 1'b0, pwrite1 = 1'b0, pen1 = 1'b0;
    logic [7:0]  paddr1 = 8'h0;
    logic [31:0] pwdata1 = 32'h0;
    logic [31:0] prdata1;
    logic        pready1, pslverr1, cfg_update1, cfg_valid1, proto_err1;
    logic [7:0]  mac1_cfg1;
    logic [15:0] mac2_cfg1, fir_cfg1;
    logic [47:0] mac_addr1;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    tsmac_apb_cfg_slave #(
        .WAIT_STATES(0), .MAC1_RST(8'hA5), .MAC2_RST(16'hBEEF), .FIR_RST(16'h0F0F)
    ) dut0 (
        .pclk(pclk), .presetn(presetn), .pselx(pselx), .pwrite(pwrite), .penable(penable),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .mac1_cfg(mac1_cfg), .mac2_cfg(mac2_cfg), .fir_cfg(fir_cfg), .mac_addr(mac_addr),
        .cfg_update(cfg_update), .cfg_valid(cfg_valid), .proto_err(proto_err)
    );

    tsmac_apb_cfg_slave #(
        .WAIT_STATES(2)
    ) dut1 (
        .pclk(pclk), .presetn(presetn), .pselx(psel1), .pwrite(pwrite1), .penable(pen1),
        .paddr(paddr1), .pwdata(pwdata1), .prdata(prdata1), .pready(pready1),
        .pslverr(pslverr1), .mac1_cfg(mac1_cfg1), .mac2_cfg(mac2_cfg1), .fir_cfg(fir_cfg1),
        .mac_addr(mac_addr1), .cfg_update(cfg_update1), .cfg_valid(cfg_valid1),
        .proto_err(proto_err1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        presetn = 1'b1;
        pselx = 1'b0; penable = 1'b0;
        psel1 = 1'b0; pen1 = 1'b0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b0;
        @(negedge pclk);
    endtask

    // Full SETUP/ACCESS transfer on dut0; returns data/err at completion and
    // cfg_update in the cycle after the completing edge.
    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic err, output logic upd);
        int n;
        pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        n = 0;
        while (pready !== 1'b1 && n < 10) begin
            @(negedge pclk);
            n++;
        end
        check("pready_timeout", 64'(n < 10), 64'(1));
        rd  = prdata;
        err = pslverr;
        @(posedge pclk);
        #1 pselx = 1'b0; penable = 1'b0;
        @(negedge pclk);
        upd = cfg_update;
    endtask

    logic [31:0] rd;
    logic        err, upd;
    int          upd_cnt, err_cnt;

    initial begin
        do_reset();
        check("rst_mac1", 64'(mac1_cfg), 64'(8'hA5));
        check("rst_mac2", 64'(mac2_cfg), 64'(16'hBEEF));
        check("rst_fir", 64'(fir_cfg), 64'(16'h0F0F));
        check("rst_mac_addr", 64'(mac_addr), 64'(0));
        check("rst_flags", 64'({cfg_update, cfg_valid, proto_err, pready, pslverr}), 64'(0));
        check("rst_prdata", 64'(prdata), 64'(0));

        // Full configuration sequence
        upd_cnt = 0; err_cnt = 0;
        apb_xfer(1'b1, 8'h00, 32'h0000_0035, rd, err, upd); upd_cnt += int'(upd);
        err_cnt += int'(err);
        apb_xfer(1'b1, 8'h01, 32'h0000_7317, rd, err, upd); upd_cnt += int'(upd);
        err_cnt += int'(err);
        apb_xfer(1'b1, 8'h12, 32'h0000_0480, rd, err, upd); upd_cnt += int'(upd);
        err_cnt += int'(err);
        apb_xfer(1'b1, 8'h13, 32'h1020_3040, rd, err, upd); upd_cnt += int'(upd);
        err_cnt += int'(err);
        check("valid_before_last", 64'(cfg_valid), 64'(0));
        apb_xfer(1'b1, 8'h14, 32'h5060_0000, rd, err, upd); upd_cnt += int'(upd);
        err_cnt += int'(err);
        check("valid_same_cycle", 64'(cfg_valid), 64'(0));
        @(negedge pclk);
        check("valid_next_cycle", 64'(cfg_valid), 64'(1));
        check("update_one_cycle", 64'(cfg_update), 64'(0));
        check("upd_pulses", 64'(upd_cnt), 64'(5));
        check("no_slverr", 64'(err_cnt), 64'(0));
        check("seq_mac1", 64'(mac1_cfg), 64'(8'h35));
        check("seq_mac2", 64'(mac2_cfg), 64'(16'h7317));
        check("seq_fir", 64'(fir_cfg), 64'(16'h0480));
        check("seq_mac_addr", 64'(mac_addr), 64'(48'h5060_1020_3040));
        apb_xfer(1'b0, 8'h20, 32'h0, rd, err, upd);
        check("status_valid", 64'(rd), 64'(32'h1));

        // Unmapped write
        do_reset();
        apb_xfer(1'b1, 8'h05, 32'hFFFF_FFFF, rd, err, upd);
        check("unmap_err", 64'(err), 64'(1));
        check("unmap_prdata", 64'(rd), 64'(0));
        check("unmap_upd", 64'(upd), 64'(0));
        check("unmap_regs", {mac1_cfg, mac2_cfg, fir_cfg, 8'h0, 16'h0},
              {8'hA5, 16'hBEEF, 16'h0F0F, 8'h0, 16'h0});
        check("unmap_mac_addr", 64'(mac_addr), 64'(0));
        @(negedge pclk);
        check("unmap_valid", 64'(cfg_valid), 64'(0));

        // Staged station address
        apb_xfer(1'b1, 8'h13, 32'hAABB_CCDD, rd, err, upd);
        check("stage_upd", 64'(upd), 64'(1));
        check("stage_no_load", 64'(mac_addr), 64'(0));
        apb_xfer(1'b0, 8'h13, 32'h0, rd, err, upd);
        check("stage_read", 64'(rd), 64'(32'hAABB_CCDD));
        apb_xfer(1'b1, 8'h14, 32'h1122_0000, rd, err, upd);
        check("mac_addr_load", 64'(mac_addr), 64'(48'h1122_AABB_CCDD));
        apb_xfer(1'b0, 8'h14, 32'h0, rd, err, upd);
        check("mac_h_read", 64'(rd), 64'(32'h1122_0000));
        check("read_no_upd", 64'(upd), 64'(0));

        // Protocol violation and W1C clear
        check("proto_clear_before", 64'(proto_err), 64'(0));
        pselx = 1'b1; penable = 1'b1;
        @(posedge pclk);
        #1 pselx = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("proto_set", 64'(proto_err), 64'(1));
        apb_xfer(1'b0, 8'h20, 32'h0, rd, err, upd);
        check("status_read", 64'(rd), 64'(32'h2));
        apb_xfer(1'b1, 8'h20, 32'h0000_0002, rd, err, upd);
        check("proto_w1c", 64'(proto_err), 64'(0));
        check("status_no_upd", 64'(upd), 64'(0));

        // Reset during ACCESS aborts the write
        pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 32'h1234;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #1 presetn = 1'b1;
        @(posedge pclk);
        #1 presetn = 1'b0; pselx = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("abort_mac2", 64'(mac2_cfg), 64'(16'hBEEF));
        check("abort_upd", 64'(cfg_update), 64'(0));
        check("abort_idle", 64'(pready), 64'(0));
        @(negedge pclk);
        check("abort_upd_late", 64'(cfg_update), 64'(0));
        check("abort_mac2_late", 64'(mac2_cfg), 64'(16'hBEEF));

        // Two wait states on dut1
        do_reset();
        psel1 = 1'b1; pen1 = 1'b0; pwrite1 = 1'b1; paddr1 = 8'h00; pwdata1 = 32'h5A;
        @(posedge pclk);
        #1 pen1 = 1'b1;
        @(negedge pclk);
        check("ws_setup_pready", 64'(pready1), 64'(0));
        @(negedge pclk);
        check("ws_acc1_pready", 64'(pready1), 64'(0));
        @(negedge pclk);
        check("ws_acc2_pready", 64'(pready1), 64'(0));
        check("ws_acc2_mac1", 64'(mac1_cfg1), 64'(0));
        @(negedge pclk);
        check("ws_acc3_pready", 64'(pready1), 64'(1));
        check("ws_acc3_mac1", 64'(mac1_cfg1), 64'(0));
        @(posedge pclk);
        #1 psel1 = 1'b0; pen1 = 1'b0;
        @(negedge pclk);
        check("ws_commit_mac1", 64'(mac1_cfg1), 64'(8'h5A));
        check("ws_commit_upd", 64'(cfg_update1), 64'(1));
        check("ws_no_proto", 64'({proto_err1, pready1}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tsmac_apb_cfg_slave.md
Name: tsmac_apb_cfg_slave

Overview:
APB slave register bank on the MAC side of the configuration path. It is driven directly by the APB configuration master (pselx/pwrite/penable/paddr/pwdata) and decodes the MAC control, filter and station-address registers. It holds those registers and presents them as static configuration outputs to the tri-speed MAC core. It also supplies read-back, error response, a commit strobe and a configuration-complete flag.

Parameters:
WAIT_STATES, 0, number of extra ACCESS cycles before pready is asserted (0..3).
MAC1_RST, 8'h00, reset value of mac1_cfg.
MAC2_RST, 16'h0000, reset value of mac2_cfg.
FIR_RST, 16'h0000, reset value of fir_cfg.

Ports:
pclk  in  1  APB clock; all logic is on the rising edge.
presetn  in  1  reset; synchronous, active-high (1 = reset).
pselx  in  1  APB select.
pwrite  in  1  1 = write, 0 = read.
penable  in  1  APB access phase.
paddr  in  8  register address.
pwdata  in  32  write data.
prdata  out  32  read data; valid while ACCESS and pready.
pready  out  1  transfer-complete indication.
pslverr  out  1  error response; valid while ACCESS and pready.
mac1_cfg  out  8  MAC1 register.
mac2_cfg  out  16  MAC2 register.
fir_cfg  out  16  address-filter register.
mac_addr  out  48  station address.
cfg_update  out  1  one-cycle pulse after any committed register write.
cfg_valid  out  1  sticky; all five config registers have been written since reset.
proto_err  out  1  sticky APB protocol violation flag.

Behaviour:
- Reset (presetn=1 at edge) sets:
  - FSM = IDLE, wait count = 0.
  - mac1_cfg = MAC1_RST, mac2_cfg = MAC2_RST, fir_cfg = FIR_RST.
  - mac_addr = 0, MAC_L staging = 0, write-seen mask = 0.
  - cfg_update = 0, cfg_valid = 0, proto_err = 0.
  - Reset mid-transfer aborts it with no register update.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: pselx=1 & penable=0 -> SETUP. pselx=1 & penable=1 -> set proto_err, stay IDLE.
  - SETUP: pselx=1 & penable=1 -> ACCESS, wait count cleared. Otherwise -> IDLE; if pselx=0 also set proto_err.
  - ACCESS: while the wait count is below WAIT_STATES, increment it.
    - pready = 1 when wait count == WAIT_STATES (combinational from state and count). pready = 0 in all other states.
    - The transfer completes on the edge where ACCESS & pready.
    - After completion: pselx=1 & penable=0 -> SETUP (back-to-back), else -> IDLE.
    - pselx or penable dropping before pready -> proto_err set, transfer abandoned, -> IDLE.
- Timing with WAIT_STATES=0: a write commits at the first ACCESS edge. The master's sequence is 1 SETUP cycle + 1 ACCESS cycle.
- Address map (paddr, latched at SETUP):
  - 0x00 MAC1, RW, bits [7:0].
  - 0x01 MAC2, RW, bits [15:0].
  - 0x12 ADDR_FIR, RW, bits [15:0].
  - 0x13 MAC_L, RW, 32 bits; the write goes to staging only.
  - 0x14 MAC_H, RW, bits [31:16]. The write atomically loads mac_addr = {pwdata[31:16], MAC_L staging}.
  - 0x20 STATUS: bit0 cfg_valid (RO), bit1 proto_err (W1C).
  - Unused register bits read 0. Writes to those bits are ignored.
- Read-back:
  - MAC_L returns staging.
  - MAC_H returns {mac_addr[47:32], 16'h0}.
- Unmapped address: pslverr=1 at completion, write ignored, prdata=0. No cfg_update, no mask bit set.
- Committed write to 0x00, 0x01, 0x12, 0x13 or 0x14:
  - cfg_update = 1 for exactly the next cycle.
  - The matching bit of the 5-bit write-seen mask is set.
  - cfg_valid is set the cycle after the mask reaches 5'h1F. It stays 1 until reset.
- A STATUS write does not pulse cfg_update.
- If a proto_err clear and a new violation occur in the same cycle, the violation wins (proto_err stays 1).
- Reads have no side effects.

Test Plan:
- Master write sequence (0x00←0x35, 0x01←0x7317, 0x12←0x0480, 0x13←0x10203040, 0x14←0x50600000), WAIT_STATES=0 -> mac1_cfg=8'h35, mac2_cfg=16'h7317, fir_cfg=16'h0480, mac_addr=48'h5060_1020_3040, five cfg_update pulses, cfg_valid=1 one cycle after the last write, pslverr never 1.
- Write 0x13←0xAABBCCDD only -> mac_addr unchanged (0). Then write 0x14←0x11220000 -> mac_addr=48'h1122_AABB_CCDD. Reading 0x14 returns 32'h1122_0000.
- Write 0x05←0xFFFFFFFF -> pslverr=1, prdata=0, no cfg_update, all registers unchanged, cfg_valid stays 0.
- penable=1 with pselx=1 while in IDLE -> proto_err=1 and STATUS read = 32'h2. Write 0x20←0x2 -> proto_err=0.
- WAIT_STATES=2: pready is first 1 in the third ACCESS cycle. A write to 0x00←0x5A commits only at that edge.
- presetn=1 in the ACCESS cycle of a write to 0x01←0x1234 -> mac2_cfg=MAC2_RST, FSM=IDLE, cfg_update=0.
